// File: rtl/ram_burst_ctrl_if.sv
// ram_burst_ctrl_if: command, write-stream, read-stream and RAM-port signals of one burst controller.
// master = client plus attached RAM; slave = the controller.
interface ram_burst_ctrl_if #(
    parameter int AWID = 8,
    parameter int DWID = 16,
    parameter int LWID = 9
);
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [AWID-1:0] cmd_addr;
    logic [LWID-1:0] cmd_len;
    logic            wr_valid, wr_ready;
    logic [DWID-1:0] wr_data;
    logic            rd_valid, rd_ready;
    logic [DWID-1:0] rd_data;
    logic            busy, done;
    logic            ram_we;
    logic [AWID-1:0] ram_addr;
    logic [DWID-1:0] ram_din, ram_dout;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_dout,
        input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, ram_we, ram_addr, ram_din
    );
    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_dout,
        output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: turns write/read burst commands into single-port RAM accesses,
// with a streaming write input and a 2-deep backpressured read output.
module ram_burst_ctrl #(
    parameter int DEPTH = 256,
    parameter int AWID  = 8,
    parameter int DWID  = 16,
    parameter int LWID  = 9
) (
    input  logic           clk,
    input  logic           rst_n,
    ram_burst_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [AWID-1:0] cur_addr_q, cur_addr_d;
    logic [LWID-1:0] remain_q, remain_d;
    logic [DWID-1:0] fifo_q [2];
    logic [1:0]      count_q, occ;
    logic            wptr_q, rptr_q, inflight_q, done_q, done_d;
    logic            accept, beat, pop, issue, step;

    assign accept = bus.cmd_valid && state_q == IDLE;
    assign beat   = bus.wr_valid && state_q == WRITE;
    assign pop    = bus.rd_valid && bus.rd_ready;
    // Words held or in flight after this cycle's pop; also the next FIFO count.
    assign occ    = count_q + {1'b0, inflight_q} - {1'b0, pop};
    assign issue  = state_q == READ && occ < 2'd2;
    assign step   = beat || issue;

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        remain_d   = remain_q;
        done_d     = 1'b0;
        if (accept) begin
            cur_addr_d = bus.cmd_addr;
            remain_d   = bus.cmd_len;
            done_d     = bus.cmd_len == '0;
            state_d    = bus.cmd_len == '0 ? IDLE : bus.cmd_write ? WRITE : READ;
        end
        if (step) begin
            cur_addr_d = cur_addr_q == AWID'(DEPTH - 1) ? '0 : cur_addr_q + 1'b1;
            remain_d   = remain_q - 1'b1;
            if (remain_q == LWID'(1)) begin
                state_d = beat ? IDLE : DRAIN;
                done_d  = beat;
            end
        end
        if (state_q == DRAIN && occ == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            remain_q   <= '0;
            done_q     <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            remain_q   <= remain_d;
            done_q     <= done_d;
            count_q    <= occ;
            inflight_q <= issue;
            if (inflight_q) begin
                fifo_q[wptr_q] <= bus.ram_dout;
                wptr_q         <= ~wptr_q;
            end
            if (pop) rptr_q <= ~rptr_q;
        end
    end

    assign bus.cmd_ready = state_q == IDLE;
    assign bus.wr_ready  = state_q == WRITE;
    assign bus.busy      = state_q != IDLE;
    assign bus.done      = done_q;
    assign bus.rd_valid  = count_q != '0;
    assign bus.rd_data   = fifo_q[rptr_q];
    assign bus.ram_we    = beat;
    assign bus.ram_addr  = cur_addr_q;
    assign bus.ram_din   = bus.wr_data;
endmodule
